// File: rtl/alu_issue_controller.sv
// alu_issue_controller: issues two-operand ALU ops from a 4x4-bit register file and writes results back
// Ports: clk/reset; instr_valid/instr/instr_ready issue handshake; ld_en/ld_addr/ld_data preload (idle only);
// alu_add/sub/lshift/rshift strobes with alu_in1/alu_in2 operands, alu_out/alu_overflow registered result;
// rd_sel/rd_data combinational register read; busy/done/flag_v status.
module alu_issue_controller #(
  parameter int ADD_LAT = 1,
  parameter int SHIFT_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_lshift,
  output logic       alu_rshift,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  input  logic [3:0] alu_out,
  input  logic       alu_overflow,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       flag_v
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
  logic [1:0] state, op, rd;
  logic [3:0] regs [4];
  logic [3:0] opa, opb;
  logic [2:0] cnt;
  logic exec;
  // outputs are masked by reset so nothing leaks out while reset is held
  assign instr_ready = state == IDLE && !reset;
  assign busy = state != IDLE && !reset;
  assign done = state == WB && !reset;
  assign exec = state == EXEC && !reset;
  assign alu_add = exec && op == 2'd0;
  assign alu_sub = exec && op == 2'd1;
  assign alu_lshift = exec && op == 2'd2;
  assign alu_rshift = exec && op == 2'd3;
  assign alu_in1 = reset ? 4'd0 : opa;
  assign alu_in2 = reset ? 4'd0 : opb;
  assign rd_data = regs[rd_sel];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      regs <= '{default: 4'd0};
      op <= 2'd0;
      rd <= 2'd0;
      opa <= 4'd0;
      opb <= 4'd0;
      cnt <= 3'd0;
      flag_v <= 1'b0;
    end else if (state == IDLE) begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (instr_valid) begin
        state <= EXEC;
        op <= instr[7:6];
        rd <= instr[5:4];
        opa <= regs[instr[3:2]];
        opb <= regs[instr[1:0]];
        cnt <= instr[7] ? 3'(SHIFT_LAT) : 3'(ADD_LAT);
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) state <= WB;
    end else begin
      if (state == WB) begin
        regs[rd] <= alu_out;
        flag_v <= alu_overflow;
      end
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_issue_controller.sv
// tb_alu_issue_controller: table, random and corner-sequence checks of alu_issue_controller
module tb_alu_issue_controller;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, ld_en = 1'b0, alu_overflow = 1'b0;
  logic [7:0] instr = 8'd0;
  logic [1:0] ld_addr = 2'd0, rd_sel = 2'd0;
  logic [3:0] ld_data = 4'd0, alu_out = 4'd0;
  logic instr_ready, alu_add, alu_sub, alu_lshift, alu_rshift, busy, done, flag_v;
  logic [3:0] alu_in1, alu_in2, rd_data;
  int passed = 0, total = 0;
  int m_reg [4];
  int m_flag = 0;

  alu_issue_controller dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lshift(alu_lshift), .alu_rshift(alu_rshift),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // registered ALU stand-in: recomputes every strobed cycle
  always @(posedge clk) begin
    if (alu_add) {alu_overflow, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
    else if (alu_sub) {alu_overflow, alu_out} <= {1'b0, alu_in1} - {1'b0, alu_in2};
    else if (alu_lshift) {alu_overflow, alu_out} <= {alu_in1, 1'b0};
    else if (alu_rshift) {alu_out, alu_overflow} <= {1'b0, alu_in1};
  end

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // reference result as plain arithmetic: returns result + 16*flag
  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    int v;
    case (op)
      0: begin r = a + b; v = r > 15 ? 1 : 0; end
      1: begin r = a - b; v = a < b ? 1 : 0; end
      2: begin r = a * 2; v = a >= 8 ? 1 : 0; end
      default: begin r = a / 2; v = a % 2; end
    endcase
    return (r & 15) + 16 * v;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk({tag, " reg"}, int'(rd_data), m_reg[i]);
    end
    chk({tag, " flag_v"}, int'(flag_v), m_flag);
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = 2'(a);
    ld_data = 4'(d);
    @(posedge clk);
    #1 ld_en = 1'b0;
    m_reg[a] = d;
  endtask

  task automatic run(input logic [7:0] ins, input int ld, input int la, input int ld_d,
                     input int noise, input string tag, output int n);
    int op, lat, a, b, e, sc, bad, opbad;
    logic [3:0] sv;
    op = int'(ins[7:6]);
    lat = op >= 2 ? 3 : 1;
    a = m_reg[ins[3:2]];
    b = m_reg[ins[1:0]];
    e = ref_alu(op, a, b);
    n = 0; sc = 0; bad = 0; opbad = 0;
    @(negedge clk);
    chk({tag, " ready"}, int'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    ld_en = ld != 0;
    ld_addr = 2'(la);
    ld_data = 4'(ld_d);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    ld_en = 1'b0;
    if (ld != 0) m_reg[la] = ld_d;
    while (1) begin
      @(negedge clk);
      n++;
      if (done || n > 20) break;
      sv = {alu_rshift, alu_lshift, alu_sub, alu_add};
      if (sv == 4'(1 << op)) sc++;
      else bad++;
      if (int'(alu_in1) != a || int'(alu_in2) != b) opbad++;
      if (noise != 0) begin
        ld_en = 1'($urandom);
        ld_addr = 2'($urandom);
        ld_data = 4'($urandom);
      end
    end
    ld_en = 1'b0;
    chk({tag, " latency"}, n, lat + 1);
    chk({tag, " strobe cycles"}, sc, lat);
    chk({tag, " wrong strobe cycles"}, bad, 0);
    chk({tag, " operand errors"}, opbad, 0);
    @(posedge clk);
    m_reg[ins[5:4]] = e % 16;
    m_flag = e / 16;
    @(negedge clk);
    chk({tag, " idle after wb"}, int'(busy), 0);
    check_regs(tag);
  endtask

  typedef struct {
    int r1;
    int r2;
    logic [7:0] ins;
    int rd;
    int res;
    int ov;
    int lat;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int n, cyc, rbad, dn;
    int acc[$];
    tbl[0] = '{5, 3, 8'h06, 0, 8, 0, 2};
    tbl[1] = '{3, 5, 8'h76, 3, 14, 1, 2};
    tbl[2] = '{9, 0, 8'h94, 1, 2, 1, 4};
    tbl[3] = '{0, 3, 8'hE8, 2, 1, 1, 4};
    tbl[4] = '{0, 8, 8'h1A, 1, 0, 1, 2};
    tbl[5] = '{7, 7, 8'h56, 1, 0, 0, 2};
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    @(negedge clk);
    chk("reset ready", int'(instr_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset strobes", int'({alu_add, alu_sub, alu_lshift, alu_rshift}), 0);
    chk("reset in1", int'(alu_in1), 0);
    chk("reset in2", int'(alu_in2), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset ready", int'(instr_ready), 1);
    check_regs("post-reset");

    for (int i = 0; i < 6; i++) begin
      preload(1, tbl[i].r1);
      preload(2, tbl[i].r2);
      run(tbl[i].ins, 0, 0, 0, 0, $sformatf("tbl%0d", i), n);
      chk($sformatf("tbl%0d done latency", i), n, tbl[i].lat);
      rd_sel = 2'(tbl[i].rd);
      #1;
      chk($sformatf("tbl%0d result", i), int'(rd_data), tbl[i].res);
      chk($sformatf("tbl%0d flag", i), int'(flag_v), tbl[i].ov);
    end

    // load and accept on the same edge: operands use old R1, load lands, rd=R0 gets 3+3
    preload(1, 3);
    run(8'h05, 1, 1, 7, 0, "ld+accept", n);
    chk("ld+accept R0", m_reg[0], 6);
    chk("ld+accept R1", m_reg[1], 7);
    // same-edge load and writeback to the same register: writeback wins later
    run(8'h25, 1, 2, 9, 1, "ld same rd", n);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1) == 1) preload(int'($urandom_range(3)), int'($urandom_range(15)));
      run(8'($urandom), $urandom_range(3) == 0 ? 1 : 0, int'($urandom_range(3)),
          int'($urandom_range(15)), 1, $sformatf("rnd%0d", k), n);
    end

    // back-to-back adds with instr_valid held high
    preload(1, 2);
    preload(2, 3);
    cyc = 0;
    rbad = 0;
    @(negedge clk);
    instr = 8'h06;
    instr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (instr_ready && instr_valid) acc.push_back(cyc);
      if (instr_ready == busy) rbad++;
      if (acc.size() == 4 && instr_valid) begin
        @(posedge clk);
        #1 instr_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b accepts", acc.size(), 4);
    for (int k = 1; k < 4 && k < acc.size(); k++) chk("b2b spacing", acc[k] - acc[k - 1], 3);
    chk("b2b ready vs busy errors", rbad, 0);
    m_reg[0] = 5;
    m_flag = 0;
    check_regs("b2b");

    // reset during the second EXEC cycle of a shift
    preload(1, 9);
    @(negedge clk);
    instr = 8'h94;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst exec strobes", int'({alu_add, alu_sub, alu_lshift, alu_rshift}), 0);
    chk("rst exec busy", int'(busy), 0);
    chk("rst exec ready while reset", int'(instr_ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_flag = 0;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("rst exec no done", dn, 0);
    chk("rst exec ready after", int'(instr_ready), 1);
    chk("rst exec in1", int'(alu_in1), 0);
    check_regs("rst exec");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
